hazard_unit_mc: RTL and testbench

//   Pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W), second generation.

---
 rtl/hazard_unit_mc_if.sv | 41 ++++
 rtl/hazard_unit_mc.sv | 117 +++++++++++
 tb/tb_hazard_unit_mc.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_mc_if.sv
// Hazard-unit bundle: pipeline stage info from the datapath, stall/flush/forward controls back.
// master = datapath side, slave = hazard unit.
interface hazard_unit_mc_if #(
   parameter int REG_AW = 5
);
   logic [REG_AW-1:0] rsD, rtD;
   logic              branchD, jrD;
   logic [REG_AW-1:0] rsE, rtE, writeregE;
   logic              regwriteE, memtoregE, div_startE;
   logic [REG_AW-1:0] writeregM;
   logic              regwriteM, memtoregM;
   logic [31:0]       exc_typeM, epcM;
   logic [REG_AW-1:0] writeregW;
   logic              regwriteW;
   logic              i_stall, d_stall;

   logic              forwardaD, forwardbD;
   logic [1:0]        forwardaE, forwardbE;
   logic              stallF, stallD, stallE, stallM, stallW;
   logic              flushF, flushD, flushE, flushM, flushW;
   logic [31:0]       newPC;
   logic              div_busy;

   modport master (
      output rsD, rtD, branchD, jrD, rsE, rtE, writeregE, regwriteE, memtoregE, div_startE,
             writeregM, regwriteM, memtoregM, exc_typeM, epcM, writeregW, regwriteW,
             i_stall, d_stall,
      input  forwardaD, forwardbD, forwardaE, forwardbE,
             stallF, stallD, stallE, stallM, stallW,
             flushF, flushD, flushE, flushM, flushW, newPC, div_busy
   );

   modport slave (
      input  rsD, rtD, branchD, jrD, rsE, rtE, writeregE, regwriteE, memtoregE, div_startE,
             writeregM, regwriteM, memtoregM, exc_typeM, epcM, writeregW, regwriteW,
             i_stall, d_stall,
      output forwardaD, forwardbD, forwardaE, forwardbE,
             stallF, stallD, stallE, stallM, stallW,
             flushF, flushD, flushE, flushM, flushW, newPC, div_busy
   );
endinterface

// File: rtl/hazard_unit_mc.sv
// 5-stage hazard controller: forward selects, load/branch/divide stalls, exception flush/redirect.
// Outputs are combinational (zero latency); an SRAM wait overrides everything and freezes internal state.
module hazard_unit_mc #(
   parameter int          REG_AW     = 5,
   parameter int          DIV_CYCLES = 34,
   parameter logic [31:0] EXC_VEC    = 32'hBFC00380,
   parameter logic [31:0] ERET_CODE  = 32'h0000000E
) (
   input logic             clk,
   input logic             rst,
   hazard_unit_mc_if.slave hz
);
   localparam int                CW       = $clog2(DIV_CYCLES);
   localparam logic [CW-1:0]     CNT_LOAD = CW'(DIV_CYCLES - 2);
   localparam logic [REG_AW-1:0] REG_ZERO = '0;

   typedef enum logic [1:0] {IDLE, RUN, DONE} divState_t;

   divState_t   state;
   logic [CW-1:0] cnt;
   logic        divBusy;
   logic        excPend;
   logic [31:0] pcPend;
   logic [31:0] excPC;
   logic        memStall, excRaw, exc;
   logic        lwStall, brStall, divStall;
   logic [4:0]  stallV, flushV;

   assign hz.forwardaE = (hz.rsE != REG_ZERO && hz.regwriteM && hz.rsE == hz.writeregM) ? 2'b10 :
                         (hz.rsE != REG_ZERO && hz.regwriteW && hz.rsE == hz.writeregW) ? 2'b01 : 2'b00;
   assign hz.forwardbE = (hz.rtE != REG_ZERO && hz.regwriteM && hz.rtE == hz.writeregM) ? 2'b10 :
                         (hz.rtE != REG_ZERO && hz.regwriteW && hz.rtE == hz.writeregW) ? 2'b01 : 2'b00;
   assign hz.forwardaD = hz.rsD != REG_ZERO && hz.regwriteM && hz.rsD == hz.writeregM;
   assign hz.forwardbD = hz.rtD != REG_ZERO && hz.regwriteM && hz.rtD == hz.writeregM;

   assign lwStall = hz.memtoregE && (hz.rtE == hz.rsD || hz.rtE == hz.rtD);

   // jr only reads rs, so its compare ignores rtD
   assign brStall =
      (hz.branchD && ((hz.regwriteE && (hz.writeregE == hz.rsD || hz.writeregE == hz.rtD)) ||
                      (hz.memtoregM && (hz.writeregM == hz.rsD || hz.writeregM == hz.rtD)))) ||
      (hz.jrD     && ((hz.regwriteE && hz.writeregE == hz.rsD) ||
                      (hz.memtoregM && hz.writeregM == hz.rsD)));

   assign memStall = hz.i_stall | hz.d_stall;
   assign excRaw   = |hz.exc_typeM;
   assign exc      = excRaw | excPend;
   assign divStall = hz.div_startE && (state != DONE);
   assign excPC    = (hz.exc_typeM == ERET_CODE) ? hz.epcM : EXC_VEC;

   assign hz.newPC    = excPend ? pcPend : excPC;
   assign hz.div_busy = divBusy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         divBusy <= 1'b0;
         excPend <= 1'b0;
         pcPend  <= '0;
      end else if (memStall) begin
         // Hold the first redirect seen while the memory wait keeps M frozen
         if (excRaw && !excPend) begin
            excPend <= 1'b1;
            pcPend  <= excPC;
         end
      end else begin
         excPend <= 1'b0;
         if (exc) begin
            state   <= IDLE;
            divBusy <= 1'b0;
         end else begin
            case (state)
               IDLE: if (hz.div_startE) begin
                  state   <= RUN;
                  cnt     <= CNT_LOAD;
                  divBusy <= 1'b1;
               end
               // Leave RUN one count early: issue cycle + RUN + DONE release = DIV_CYCLES in E
               RUN: if (cnt <= CW'(1)) begin
                  state <= DONE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt - CW'(1);
               end
               DONE: begin
                  state   <= IDLE;
                  divBusy <= 1'b0;
               end
               default: begin
                  state   <= IDLE;
                  divBusy <= 1'b0;
               end
            endcase
         end
      end
   end

   always_comb begin
      stallV = 5'b00000;
      flushV = 5'b00000;
      if (memStall) begin
         stallV = 5'b11111;
      end else if (exc) begin
         flushV = 5'b11111;
      end else if (divStall) begin
         stallV = 5'b11100;
         flushV = 5'b00010;
      end else if (lwStall || brStall) begin
         stallV = 5'b11000;
         flushV = 5'b00100;
      end
   end

   assign {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW} = stallV;
   assign {hz.flushF, hz.flushD, hz.flushE, hz.flushM, hz.flushW} = flushV;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed bench for hazard_unit_mc: stimulus pushes hand-computed expectations, a monitor
// pops one per cycle on the falling edge and compares the full output set.
module tb_hazard_unit_mc;
   localparam logic [31:0] EXC_VEC = 32'hBFC00380;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hazard_unit_mc_if #(.REG_AW(5)) hzif ();

   hazard_unit_mc #(
      .REG_AW(5), .DIV_CYCLES(34), .EXC_VEC(32'hBFC00380), .ERET_CODE(32'h0000000E)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz (hzif)
   );

   typedef struct packed {
      logic [1:0]  faE;
      logic [1:0]  fbE;
      logic        faD;
      logic        fbD;
      logic [4:0]  stall;
      logic [4:0]  flush;
      logic [31:0] pc;
      logic        busy;
   } obs_t;

   typedef struct {
      string tag;
      obs_t  e;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic obs_t mk(input logic [4:0] st, input logic [4:0] fl, input logic busy);
      obs_t o;
      o       = '0;
      o.stall = st;
      o.flush = fl;
      o.pc    = EXC_VEC;
      o.busy  = busy;
      return o;
   endfunction

   function automatic obs_t fw(input logic [1:0] a, input logic [1:0] b,
                               input logic ad, input logic bd);
      obs_t o;
      o     = mk(5'b0, 5'b0, 1'b0);
      o.faE = a;
      o.fbE = b;
      o.faD = ad;
      o.fbD = bd;
      return o;
   endfunction

   task automatic cyc(input string tag, input obs_t e);
      exp_t x;
      x.tag = tag;
      x.e   = e;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      hzif.rsD = '0;        hzif.rtD = '0;        hzif.branchD = 1'b0;   hzif.jrD = 1'b0;
      hzif.rsE = '0;        hzif.rtE = '0;        hzif.writeregE = '0;
      hzif.regwriteE = 1'b0; hzif.memtoregE = 1'b0; hzif.div_startE = 1'b0;
      hzif.writeregM = '0;  hzif.regwriteM = 1'b0; hzif.memtoregM = 1'b0;
      hzif.exc_typeM = '0;  hzif.epcM = '0;
      hzif.writeregW = '0;  hzif.regwriteW = 1'b0;
      hzif.i_stall = 1'b0;  hzif.d_stall = 1'b0;
   endtask

   initial begin
      forever begin
         exp_t x;
         obs_t a;
         @(negedge clk);
         if (sb.size() > 0) begin
            x = sb.pop_front();
            a = {hzif.forwardaE, hzif.forwardbE, hzif.forwardaD, hzif.forwardbD,
                 hzif.stallF, hzif.stallD, hzif.stallE, hzif.stallM, hzif.stallW,
                 hzif.flushF, hzif.flushD, hzif.flushE, hzif.flushM, hzif.flushW,
                 hzif.newPC, hzif.div_busy};
            checks++;
            if (a !== x.e) begin
               errors++;
               $display("FAIL %s got=%h expected=%h", x.tag, a, x.e);
            end
         end
      end
   end

   initial begin
      @(posedge clk);
      #1;
      quiet();
      rst = 1'b1;
      cyc("reset", mk(5'b0, 5'b0, 1'b0));
      rst = 1'b0;
      cyc("idle", mk(5'b0, 5'b0, 1'b0));

      // Forwarding
      hzif.rsE = 5'd3; hzif.rtE = 5'd3; hzif.writeregM = 5'd3; hzif.regwriteM = 1'b1;
      hzif.writeregW = 5'd3; hzif.regwriteW = 1'b1;
      cyc("fwd_m_wins", fw(2'b10, 2'b10, 1'b0, 1'b0));
      hzif.rsE = 5'd0; hzif.rtE = 5'd0; hzif.writeregM = 5'd0; hzif.writeregW = 5'd0;
      cyc("fwd_r0", fw(2'b00, 2'b00, 1'b0, 1'b0));
      hzif.rsE = 5'd4; hzif.rtE = 5'd3; hzif.writeregM = 5'd3; hzif.writeregW = 5'd4;
      cyc("fwd_w_m", fw(2'b01, 2'b10, 1'b0, 1'b0));
      hzif.rsE = 5'd3; hzif.rtE = 5'd3; hzif.regwriteM = 1'b0; hzif.writeregW = 5'd3;
      cyc("fwd_m_nowrite", fw(2'b01, 2'b01, 1'b0, 1'b0));
      quiet();
      hzif.rsD = 5'd9; hzif.rtD = 5'd3; hzif.writeregM = 5'd3; hzif.regwriteM = 1'b1;
      cyc("fwd_d", fw(2'b00, 2'b00, 1'b0, 1'b1));

      // lw $5 then beq $5,$6
      quiet();
      hzif.memtoregE = 1'b1; hzif.regwriteE = 1'b1; hzif.writeregE = 5'd5; hzif.rtE = 5'd5;
      hzif.rsD = 5'd5; hzif.rtD = 5'd6; hzif.branchD = 1'b1;
      cyc("lwstall", mk(5'b11000, 5'b00100, 1'b0));
      hzif.memtoregE = 1'b0; hzif.regwriteE = 1'b0; hzif.writeregE = '0; hzif.rtE = '0;
      hzif.memtoregM = 1'b1; hzif.regwriteM = 1'b1; hzif.writeregM = 5'd5;
      begin
         obs_t e;
         e = mk(5'b11000, 5'b00100, 1'b0);
         e.faD = 1'b1;
         cyc("brstall_memM", e);
      end
      hzif.memtoregM = 1'b0;
      cyc("beq_fwd_m", fw(2'b00, 2'b00, 1'b1, 1'b0));

      // jr reads rs only
      quiet();
      hzif.jrD = 1'b1; hzif.rsD = 5'd7; hzif.rtD = 5'd8; hzif.regwriteE = 1'b1; hzif.writeregE = 5'd8;
      cyc("jr_rt_ignored", mk(5'b0, 5'b0, 1'b0));
      hzif.writeregE = 5'd7;
      cyc("jr_rs_stall", mk(5'b11000, 5'b00100, 1'b0));
      hzif.jrD = 1'b0; hzif.branchD = 1'b1; hzif.writeregE = 5'd8;
      cyc("beq_rt_stall", mk(5'b11000, 5'b00100, 1'b0));

      // Divide: 34 cycles in E, 33 stalled
      quiet();
      for (int k = 0; k < 34; k++) begin
         hzif.div_startE = 1'b1;
         if (k == 33) cyc("div_done", mk(5'b00000, 5'b00000, 1'b1));
         else         cyc("div_run", mk(5'b11100, 5'b00010, k != 0));
      end

      // Back-to-back divide with a 5-cycle data wait: 39 cycles in E
      for (int k = 0; k < 39; k++) begin
         hzif.div_startE = 1'b1;
         hzif.d_stall    = (k >= 11 && k <= 15);
         if (k >= 11 && k <= 15) cyc("div_memstall", mk(5'b11111, 5'b00000, 1'b1));
         else if (k == 38)       cyc("div2_done", mk(5'b00000, 5'b00000, 1'b1));
         else                    cyc("div2_run", mk(5'b11100, 5'b00010, k != 0));
      end
      quiet();
      cyc("div2_idle", mk(5'b0, 5'b0, 1'b0));

      // Exception held across data wait
      hzif.exc_typeM = 32'h4; hzif.d_stall = 1'b1;
      for (int k = 0; k < 3; k++) cyc("exc_hold", mk(5'b11111, 5'b00000, 1'b0));
      hzif.d_stall = 1'b0;
      cyc("exc_flush", mk(5'b00000, 5'b11111, 1'b0));
      quiet();
      cyc("exc_after", mk(5'b0, 5'b0, 1'b0));

      // eret redirect captured while waiting; M cleared at release
      hzif.exc_typeM = 32'hE; hzif.epcM = 32'h80000010; hzif.i_stall = 1'b1;
      begin
         obs_t e;
         e    = mk(5'b11111, 5'b00000, 1'b0);
         e.pc = 32'h80000010;
         for (int k = 0; k < 3; k++) cyc("eret_hold", e);
         quiet();
         e    = mk(5'b00000, 5'b11111, 1'b0);
         e.pc = 32'h80000010;
         cyc("eret_pend_flush", e);
      end
      cyc("eret_after", mk(5'b0, 5'b0, 1'b0));

      // eret aborts a running divide
      hzif.div_startE = 1'b1;
      cyc("div3_issue", mk(5'b11100, 5'b00010, 1'b0));
      for (int k = 0; k < 3; k++) cyc("div3_run", mk(5'b11100, 5'b00010, 1'b1));
      hzif.exc_typeM = 32'hE; hzif.epcM = 32'h80001234;
      begin
         obs_t e;
         e    = mk(5'b00000, 5'b11111, 1'b1);
         e.pc = 32'h80001234;
         cyc("eret_div_flush", e);
      end
      quiet();
      cyc("div3_aborted", mk(5'b0, 5'b0, 1'b0));

      // Exception blocks divide issue
      hzif.div_startE = 1'b1; hzif.exc_typeM = 32'h4;
      cyc("exc_blocks_div", mk(5'b00000, 5'b11111, 1'b0));
      hzif.exc_typeM = '0;
      cyc("div4_issue", mk(5'b11100, 5'b00010, 1'b0));
      cyc("div4_run", mk(5'b11100, 5'b00010, 1'b1));

      // Reset mid-divide
      rst = 1'b1;
      hzif.div_startE = 1'b0;
      cyc("reset_mid_div", mk(5'b0, 5'b0, 1'b0));
      rst = 1'b0;
      cyc("post_reset", mk(5'b0, 5'b0, 1'b0));

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain left=%0d expected=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
